shared_bundle_reg_arbiter: RTL and testbench
============================================

Name: shared_bundle_reg_arbiter

Overview:
Shares one two-field bundle register {a, b} among NUM_REQ requesters, using round-robin arbitration with a valid/ready handshake.
- A small FSM sequences each grant as select, then write, then optional cooldown.
- Exposes the registered OR-reduction out = a | b, plus grant and write-count status.
- Sits in front of the bundle-register datapath; replaces the single io_something write-enable with an arbitrated write port.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HOLD_CYCLES, 2, idle cycles enforced after each write before the next arbitration (0..15).
- CNT_W, 16, width of the saturating write counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_a  input  NUM_REQ  per-requester field a (bit i belongs to requester i)
- req_b  input  NUM_REQ  per-requester field b
- req_ready  output  NUM_REQ  one-hot write acknowledge
- out  output  1  reg_a | reg_b
- out_valid  output  1  high once reg_b has been written since reset
- grant_id  output  $clog2(NUM_REQ)  requester of the most recent completed write
- busy  output  1  FSM not in IDLE
- write_count  output  CNT_W  completed writes, saturating at all-ones

Behaviour:
- Reset (clk edge with reset=1):
  - reg_a=0, reg_b=0, out_valid=0.
  - grant_id=0, write_count=0, rr_ptr=0.
  - State=IDLE, req_ready=0.
  - Reset mid-operation aborts any grant: no write, no ready.
- States: IDLE, WRITE, COOLDOWN.
- IDLE:
  - If req_valid is nonzero, pick the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner into the internal grant register and go to WRITE.
  - Otherwise stay in IDLE.
- WRITE (exactly one cycle):
  - If req_valid[grant] is still 1:
    - req_ready[grant]=1 combinationally.
    - reg_a<=req_a[grant], reg_b<=req_b[grant], out_valid<=1.
    - grant_id<=grant, write_count increments (saturating).
    - rr_ptr<=(grant+1) mod NUM_REQ.
    - Next state is COOLDOWN if HOLD_CYCLES>0, else IDLE.
  - If req_valid[grant] dropped:
    - No write and no ready; rr_ptr is unchanged.
    - Next state is IDLE (no cooldown).
- COOLDOWN:
  - A down-counter loads HOLD_CYCLES on entry.
  - Stay for HOLD_CYCLES cycles, then go to IDLE.
  - Requests are ignored; req_ready stays 0.
- Handshake timing:
  - Requester asserts valid with stable data until it sees ready.
  - Transfer occurs on the clk edge where valid & ready.
  - Ready comes at the earliest 1 cycle after valid is first seen in IDLE.
  - New out is visible the cycle after ready.
- Write spacing: minimum 2+HOLD_CYCLES cycles between consecutive writes.
- Outputs:
  - out is combinational from the registers (reg_a | reg_b) and is valid after reset.
  - busy = (state != IDLE).
- Simultaneous requests: exactly one grant per arbitration, never more than one bit of req_ready set.
- Fairness: a continuously asserted request is granted within NUM_REQ arbitrations.
- Wrap-around: rr_ptr after grant NUM_REQ-1 is 0.
- Counter saturation: write_count holds at 2^CNT_W-1.

Decomposition:
- Package shared_bundle_reg_arbiter_pkg:
  - State enum {IDLE, WRITE, COOLDOWN}.
  - PTR_W function ($clog2 wrapper).
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: any, idx.

Test Plan:
- Reset, then no requests → out=0, out_valid=0, busy=0, write_count=0, req_ready=0 for 20 cycles.
- req_valid=4'b0001, a=1, b=0 held from cycle 0:
  - req_ready[0]=1 at cycle 1.
  - out=1, out_valid=1, grant_id=0, write_count=1 at cycle 2.
  - busy stays high through cycle 3 (COOLDOWN, HOLD_CYCLES=2).
- All four requesters valid continuously, distinct data:
  - Grants in order 0,1,2,3,0.
  - Ready pulses exactly 4 cycles apart.
  - write_count=5 after the fifth grant.
- rr_ptr=3 with requests 4'b1001:
  - Grant 3 first, then wrap to grant 0.
- Requester 2 drops valid in the WRITE cycle:
  - No ready, registers unchanged, FSM back to IDLE the next cycle.
  - rr_ptr unchanged, so requester 2 is the next granted when it reasserts.
- Assert reset during COOLDOWN after a write of a=1, b=1:
  - Next cycle out=0, out_valid=0, state IDLE, write_count=0.
- CNT_W=2 with 5 writes → write_count saturates at 3.

Source files
------------

// File: rtl/shared_bundle_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin bundle-register arbiter.
package shared_bundle_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   localparam int HOLD_W = 4;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_bundle_reg_arbiter_if.sv
// Per-requester write port bundle: one bit of each vector per requester.
interface shared_bundle_reg_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_a;
   logic [NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0] req_ready;

   modport master (output req_valid, req_a, req_b, input req_ready);
   modport slave  (input req_valid, req_a, req_b, output req_ready);
endinterface

// File: rtl/shared_bundle_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module shared_bundle_reg_arbiter_rr_pick
   import shared_bundle_reg_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = ptr_w(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic               any,
   output logic [PTR_W-1:0]   idx
);

   // Scan from the farthest offset down so the nearest offset wins last.
   always_comb begin
      int               j;
      logic [PTR_W-1:0] j_idx;
      j     = 0;
      j_idx = '0;
      any   = 1'b0;
      idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         j_idx = PTR_W'(j);
         if (req[j_idx]) begin
            any = 1'b1;
            idx = j_idx;
         end
      end
   end

endmodule

// File: rtl/shared_bundle_reg_arbiter.sv
// Round-robin arbitrated write port in front of the {a, b} bundle register.
// state    | meaning
// IDLE     | waiting for any req_valid; arbitrates and latches the winner
// WRITE    | one cycle; acknowledges and writes if the winner is still valid
// COOLDOWN | HOLD_CYCLES idle cycles after a write, requests ignored
module shared_bundle_reg_arbiter
   import shared_bundle_reg_arbiter_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int HOLD_CYCLES = 2,
   parameter  int CNT_W       = 16,
   localparam int PTR_W       = ptr_w(NUM_REQ)
)(
   input  logic                       clk,
   input  logic                       reset,
   shared_bundle_reg_arbiter_if.slave bus,
   output logic                       out,
   output logic                       out_valid,
   output logic [PTR_W-1:0]           grant_id,
   output logic                       busy,
   output logic [CNT_W-1:0]           write_count
);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   grant_q;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [HOLD_W-1:0]  hold_cnt_q;
   logic               reg_a, reg_b;
   logic               pick_any;
   logic [PTR_W-1:0]   pick_idx;
   logic               do_write;
   logic [NUM_REQ-1:0] ready_c;

   shared_bundle_reg_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      do_write = 1'b0;
      ready_c  = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) state_d = WRITE;
         end
         WRITE: begin
            // A requester that withdrew loses the slot; no cooldown is charged.
            if (bus.req_valid[grant_q]) begin
               do_write         = 1'b1;
               ready_c[grant_q] = 1'b1;
               state_d          = (HOLD_CYCLES > 0) ? COOLDOWN : IDLE;
            end else begin
               state_d = IDLE;
            end
         end
         COOLDOWN: begin
            if (hold_cnt_q <= HOLD_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = ready_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         hold_cnt_q  <= '0;
         reg_a       <= 1'b0;
         reg_b       <= 1'b0;
         out_valid   <= 1'b0;
         grant_id    <= '0;
         write_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_any) grant_q <= pick_idx;
         if (state_q == COOLDOWN) hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
         if (do_write) begin
            reg_a      <= bus.req_a[grant_q];
            reg_b      <= bus.req_b[grant_q];
            out_valid  <= 1'b1;
            grant_id   <= grant_q;
            hold_cnt_q <= HOLD_W'(HOLD_CYCLES);
            rr_ptr_q   <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
            if (write_count != '1) write_count <= write_count + CNT_W'(1);
         end
      end
   end

   assign out  = reg_a | reg_b;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_shared_bundle_reg_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, a monitor checks each ready pulse.
module tb_shared_bundle_reg_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        out, out_valid, busy;
   logic [1:0]  grant_id;
   logic [15:0] write_count;
   logic        out2, out_valid2, busy2;
   logic [1:0]  grant_id2;
   logic [1:0]  write_count2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [3:0]  ready;
      logic        o;
      logic [1:0]  gid;
      logic [15:0] wc;
      int          gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t post_e;
   bit   post_pending = 1'b0;
   int   last_cyc = 0;
   int   last2 = 0;
   int   t2 = 0;
   int   exp_wc2 = 0;

   shared_bundle_reg_arbiter_if #(.NUM_REQ(4)) bus  ();
   shared_bundle_reg_arbiter_if #(.NUM_REQ(4)) bus2 ();

   shared_bundle_reg_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(2), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .out         (out),
      .out_valid   (out_valid),
      .grant_id    (grant_id),
      .busy        (busy),
      .write_count (write_count)
   );

   shared_bundle_reg_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(0), .CNT_W(2)) dut_sat (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus2),
      .out         (out2),
      .out_valid   (out_valid2),
      .grant_id    (grant_id2),
      .busy        (busy2),
      .write_count (write_count2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [3:0] r, input logic o, input logic [1:0] g,
                           input int w, input int gap);
      exp_t e;
      e.ready = r; e.o = o; e.gid = g; e.wc = 16'(w); e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b);
      bus.req_valid = v;
      bus.req_a     = a;
      bus.req_b     = b;
   endtask

   task automatic wait_readies(input int n);
      int seen = 0;
      int t    = 0;
      while (seen < n && t < 60) begin
         @(negedge clk);
         t++;
         if (bus.req_ready !== 4'b0) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: got %0d pulses, want %0d", seen, n);
      end
   endtask

   // Monitor: every ready pulse pops one expectation; the next cycle checks the write.
   initial begin
      forever begin
         @(negedge clk);
         if (post_pending) begin
            post_pending = 1'b0;
            checks++;
            if ({out, out_valid, grant_id, write_count} !== {post_e.o, 1'b1, post_e.gid, post_e.wc}) begin
               errors++;
               $display("FAIL post_write: got out=%0b ov=%0b gid=%0d wc=%0d, want out=%0b ov=1 gid=%0d wc=%0d",
                        out, out_valid, grant_id, write_count, post_e.o, post_e.gid, post_e.wc);
            end
         end
         if (!reset && bus.req_ready !== 4'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got %b, want none", bus.req_ready);
            end else begin
               mon_e = exp_q.pop_front();
               checks++;
               if (bus.req_ready !== mon_e.ready) begin
                  errors++;
                  $display("FAIL ready_vec: got %b, want %b", bus.req_ready, mon_e.ready);
               end
               if (mon_e.gap > 0) begin
                  checks++;
                  if (cyc - last_cyc != mon_e.gap) begin
                     errors++;
                     $display("FAIL ready_gap: got %0d, want %0d", cyc - last_cyc, mon_e.gap);
                  end
               end
               last_cyc     = cyc;
               post_e       = mon_e;
               post_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_req(4'b0, 4'b0, 4'b0);
      bus2.req_valid = 4'b0; bus2.req_a = 4'b0; bus2.req_b = 4'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_state", {out, out_valid, busy, write_count, bus.req_ready, grant_id}, 32'h0);
      end

      // Single requester, then cooldown occupancy
      @(posedge clk); #1;
      push_exp(4'b0001, 1'b1, 2'd0, 1, 0);
      set_req(4'b0001, 4'b0001, 4'b0000);
      wait_readies(1);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);
      @(negedge clk); chk("busy_cd1", busy, 1);
      @(negedge clk); chk("busy_cd2", busy, 1);
      @(negedge clk); chk("busy_idle", busy, 0);

      // All four continuously valid from a fresh reset
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      push_exp(4'b0001, 1'b1, 2'd0, 1, 0);
      push_exp(4'b0010, 1'b1, 2'd1, 2, 4);
      push_exp(4'b0100, 1'b1, 2'd2, 3, 4);
      push_exp(4'b1000, 1'b0, 2'd3, 4, 4);
      push_exp(4'b0001, 1'b1, 2'd0, 5, 4);
      set_req(4'b1111, 4'b0101, 4'b0010);
      wait_readies(5);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);

      // Move pointer to 3 via a grant to 2, then 3 wins and wraps to 0
      push_exp(4'b0100, 1'b1, 2'd2, 6, 0);
      set_req(4'b0100, 4'b0100, 4'b0000);
      wait_readies(1);
      @(posedge clk); #1;
      push_exp(4'b1000, 1'b0, 2'd3, 7, 4);
      push_exp(4'b0001, 1'b1, 2'd0, 8, 4);
      set_req(4'b1001, 4'b0001, 4'b0000);
      wait_readies(2);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);

      // Requester 2 withdraws during its WRITE cycle
      repeat (4) @(posedge clk);
      #1 set_req(4'b0100, 4'b0000, 4'b0000);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);
      @(negedge clk);
      chk("drop_ready", bus.req_ready, 0);
      chk("drop_busy_write", busy, 1);
      @(negedge clk);
      chk("drop_busy_idle", busy, 0);
      chk("drop_regs", {out, out_valid, grant_id, write_count}, {1'b1, 1'b1, 2'd0, 16'd8});
      @(posedge clk); #1;
      push_exp(4'b0100, 1'b1, 2'd2, 9, 0);
      push_exp(4'b1000, 1'b0, 2'd3, 10, 4);
      set_req(4'b1100, 4'b0000, 4'b0100);
      wait_readies(2);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);

      // Reset during cooldown after writing a=1, b=1
      repeat (4) @(posedge clk);
      #1;
      push_exp(4'b0001, 1'b1, 2'd0, 11, 0);
      set_req(4'b0001, 4'b0001, 4'b0001);
      wait_readies(1);
      @(posedge clk); #1;
      set_req(4'b0, 4'b0, 4'b0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cd_regs", {out, out_valid, busy, write_count}, 32'h0);

      // Saturating counter on the CNT_W=2, no-cooldown instance
      @(posedge clk); #1;
      bus2.req_valid = 4'b0001; bus2.req_a = 4'b0001; bus2.req_b = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         t2 = 0;
         @(negedge clk);
         while (bus2.req_ready[0] !== 1'b1 && t2 < 20) begin
            @(negedge clk);
            t2++;
         end
         chk("sat_ready", bus2.req_ready, 4'b0001);
         if (k > 0) chk("sat_gap", cyc - last2, 2);
         last2 = cyc;
         @(negedge clk);
         exp_wc2 = (k + 1 > 3) ? 3 : k + 1;
         chk("sat_count", write_count2, exp_wc2);
      end
      @(posedge clk); #1;
      bus2.req_valid = 4'b0;

      repeat (3) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
